// File: rtl/sccb_pkg.sv
// ============================================================================
// Module : sccb_pkg
// Brief  : Shared codes, register map and state encodings for the SCCB master.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sccb_pkg;

    localparam logic [2:0] MCMD_IDLE = 3'd0;
    localparam logic [2:0] MCMD_WR   = 3'd1;
    localparam logic [2:0] MCMD_RD   = 3'd2;

    localparam logic [1:0] SRESP_NULL = 2'd0;
    localparam logic [1:0] SRESP_DVA  = 2'd1;
    localparam logic [1:0] SRESP_FAIL = 2'd2;
    localparam logic [1:0] SRESP_ERR  = 2'd3;

    localparam logic [7:0] ADDR_CTRL    = 8'h00;
    localparam logic [7:0] ADDR_STATUS  = 8'h01;
    localparam logic [7:0] ADDR_DEVADDR = 8'h02;
    localparam logic [7:0] ADDR_SUBADDR = 8'h03;
    localparam logic [7:0] ADDR_WDATA   = 8'h04;
    localparam logic [7:0] ADDR_RDATA   = 8'h05;

    localparam int CTRL_START_WR = 0;
    localparam int CTRL_START_RD = 1;
    localparam int STAT_BUSY     = 0;
    localparam int STAT_NACK     = 1;
    localparam int STAT_DONE     = 2;

    localparam logic [6:0] DEVADDR_RST = 7'h21;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_TXBYTE = 3'd2;
    localparam logic [2:0] ST_TXACK  = 3'd3;
    localparam logic [2:0] ST_RXBYTE = 3'd4;
    localparam logic [2:0] ST_RXNACK = 3'd5;
    localparam logic [2:0] ST_STOP   = 3'd6;
    localparam logic [2:0] ST_GAP    = 3'd7;

    // Byte selector: which byte of the transaction is on the wire
    localparam logic [1:0] PH_IDW   = 2'd0;
    localparam logic [1:0] PH_SUB   = 2'd1;
    localparam logic [1:0] PH_WDATA = 2'd2;
    localparam logic [1:0] PH_IDR   = 2'd3;

    localparam logic [1:0] OP_START = 2'd0;
    localparam logic [1:0] OP_STOP  = 2'd1;
    localparam logic [1:0] OP_BIT   = 2'd2;
    localparam logic [1:0] OP_GAP   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sccb_phy.sv
// ============================================================================
// Module : sccb_phy
// Brief  : Quarter-period timer generating SCCB start/stop/bit/gap primitives.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_phy
    import sccb_pkg::*;
#(
    parameter int QTR_DIV = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic [1:0] op,
    input  logic       tx_bit,
    input  logic       siod_in,
    output logic       done,
    output logic       rx_bit,
    output logic       sioc,
    output logic       siod_oe
);

    localparam int             CW       = $clog2(QTR_DIV);
    localparam logic [CW-1:0]  QTR_LAST = CW'(QTR_DIV - 1);

    logic [1:0]    sync;
    logic          active;
    logic [1:0]    cur_op;
    logic          cur_bit;
    logic [1:0]    qtr;
    logic [CW-1:0] qcnt;
    logic          qtr_end;
    logic          last_qtr;
    logic          sioc_nxt;
    logic          oe_nxt;

    assign qtr_end = (qcnt == QTR_LAST);

    always_comb begin
        sioc_nxt = 1'b1;
        oe_nxt   = 1'b0;
        last_qtr = (qtr == 2'd3);
        case (cur_op)
            OP_START: begin
                // two quarters of SIOD low under SIOC high, then SIOC drops
                sioc_nxt = (qtr != 2'd2);
                oe_nxt   = 1'b1;
                last_qtr = (qtr == 2'd2);
            end
            OP_STOP: begin
                sioc_nxt = (qtr != 2'd0);
                oe_nxt   = !qtr[1];
            end
            OP_BIT: begin
                sioc_nxt = (qtr == 2'd1) || (qtr == 2'd2);
                oe_nxt   = !cur_bit;
            end
            default: begin
                sioc_nxt = 1'b1;
                oe_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= 2'b11;
            active  <= 1'b0;
            cur_op  <= OP_GAP;
            cur_bit <= 1'b1;
            qtr     <= 2'd0;
            qcnt    <= '0;
            done    <= 1'b0;
            rx_bit  <= 1'b1;
            sioc    <= 1'b1;
            siod_oe <= 1'b0;
        end else begin
            sync <= {sync[0], siod_in};
            done <= 1'b0;
            if (active) begin
                sioc    <= sioc_nxt;
                siod_oe <= oe_nxt;
                if (cur_op == OP_BIT && qtr == 2'd1 && qtr_end) begin
                    rx_bit <= sync[1];
                end
                if (qtr_end) begin
                    qcnt <= '0;
                    if (last_qtr) begin
                        active <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        qtr <= qtr + 2'd1;
                    end
                end else begin
                    qcnt <= qcnt + 1'b1;
                end
            end else if (req) begin
                active  <= 1'b1;
                cur_op  <= op;
                cur_bit <= tx_bit;
                qtr     <= 2'd0;
                qcnt    <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sccb_ctrl.sv
// ============================================================================
// Module : sccb_ctrl
// Brief  : OCP register slave sequencing SCCB register writes and reads.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sccb_ctrl
    import sccb_pkg::*;
#(
    parameter int QTR_DIV = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] sccb_MCmd,
    input  logic [7:0] sccb_MAddr,
    input  logic [7:0] sccb_MData,
    output logic       sccb_SCmdAccept,
    output logic [7:0] sccb_SData,
    output logic [1:0] sccb_SResp,
    output logic       sioc,
    output logic       siod_oe,
    input  logic       siod_in,
    output logic       busy
);

    logic [2:0] state;
    logic       issued;
    logic [1:0] phase;
    logic [2:0] bitcnt;
    logic [7:0] shreg;
    logic [6:0] devaddr, sh_dev;
    logic [7:0] subaddr, sh_sub;
    logic [7:0] wdata, sh_wdata;
    logic [7:0] rdata;
    logic       is_read;
    logic       st_done, st_nack;

    logic       is_wr, is_rd;
    logic       start_req, start_rd;
    logic       wr_dev, wr_sub, wr_wdata;
    logic [1:0] resp_nxt;
    logic [7:0] sdata_nxt;

    logic       phy_req, phy_done, phy_rx, phy_tx;
    logic [1:0] phy_op;

    assign busy            = (state != ST_IDLE);
    assign is_wr           = (sccb_MCmd == MCMD_WR);
    assign is_rd           = (sccb_MCmd == MCMD_RD);
    assign sccb_SCmdAccept = is_wr || is_rd;

    always_comb begin
        resp_nxt  = SRESP_NULL;
        sdata_nxt = 8'h00;
        start_req = 1'b0;
        start_rd  = 1'b0;
        wr_dev    = 1'b0;
        wr_sub    = 1'b0;
        wr_wdata  = 1'b0;
        if (is_wr) begin
            resp_nxt = SRESP_DVA;
            case (sccb_MAddr)
                ADDR_CTRL: begin
                    if (sccb_MData[CTRL_START_WR] || sccb_MData[CTRL_START_RD]) begin
                        if (busy) begin
                            resp_nxt = SRESP_FAIL;
                        end else begin
                            start_req = 1'b1;
                            start_rd  = sccb_MData[CTRL_START_RD];
                        end
                    end
                end
                ADDR_DEVADDR: wr_dev   = 1'b1;
                ADDR_SUBADDR: wr_sub   = 1'b1;
                ADDR_WDATA:   wr_wdata = 1'b1;
                default:      resp_nxt = SRESP_ERR;
            endcase
        end else if (is_rd) begin
            resp_nxt = SRESP_DVA;
            case (sccb_MAddr)
                ADDR_CTRL: sdata_nxt = 8'h00;
                ADDR_STATUS: begin
                    sdata_nxt[STAT_BUSY] = busy;
                    sdata_nxt[STAT_NACK] = st_nack;
                    sdata_nxt[STAT_DONE] = st_done;
                end
                ADDR_DEVADDR: sdata_nxt = {1'b0, devaddr};
                ADDR_SUBADDR: sdata_nxt = subaddr;
                ADDR_WDATA:   sdata_nxt = wdata;
                ADDR_RDATA:   sdata_nxt = rdata;
                default:      resp_nxt  = SRESP_ERR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sccb_SResp <= SRESP_NULL;
            sccb_SData <= 8'h00;
            devaddr    <= DEVADDR_RST;
            subaddr    <= 8'h00;
            wdata      <= 8'h00;
        end else begin
            sccb_SResp <= resp_nxt;
            sccb_SData <= sdata_nxt;
            if (wr_dev)   devaddr <= sccb_MData[6:0];
            if (wr_sub)   subaddr <= sccb_MData;
            if (wr_wdata) wdata   <= sccb_MData;
        end
    end

    // Each non-idle state issues exactly one PHY primitive and waits for its done
    assign phy_req = busy && !issued;

    always_comb begin
        phy_op = OP_BIT;
        phy_tx = 1'b1;
        case (state)
            ST_START:  phy_op = OP_START;
            ST_STOP:   phy_op = OP_STOP;
            ST_GAP:    phy_op = OP_GAP;
            ST_TXBYTE: phy_tx = shreg[bitcnt];
            default:   phy_op = OP_BIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            issued   <= 1'b0;
            phase    <= PH_IDW;
            bitcnt   <= 3'd7;
            shreg    <= 8'h00;
            sh_dev   <= 7'h00;
            sh_sub   <= 8'h00;
            sh_wdata <= 8'h00;
            is_read  <= 1'b0;
            rdata    <= 8'h00;
            st_done  <= 1'b0;
            st_nack  <= 1'b0;
        end else begin
            if (phy_req) issued <= 1'b1;
            if (phy_done) issued <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state    <= ST_START;
                        phase    <= PH_IDW;
                        is_read  <= start_rd;
                        sh_dev   <= devaddr;
                        sh_sub   <= subaddr;
                        sh_wdata <= wdata;
                        st_done  <= 1'b0;
                        st_nack  <= 1'b0;
                    end
                end
                ST_START: if (phy_done) begin
                    state  <= ST_TXBYTE;
                    bitcnt <= 3'd7;
                    shreg  <= {sh_dev, phase == PH_IDR};
                end
                ST_TXBYTE: if (phy_done) begin
                    if (bitcnt == 3'd0) state <= ST_TXACK;
                    else bitcnt <= bitcnt - 3'd1;
                end
                ST_TXACK: if (phy_done) begin
                    bitcnt <= 3'd7;
                    if (phy_rx) begin
                        st_nack <= 1'b1;
                        state   <= ST_STOP;
                    end else begin
                        case (phase)
                            PH_IDW: begin
                                phase <= PH_SUB;
                                shreg <= sh_sub;
                                state <= ST_TXBYTE;
                            end
                            PH_SUB: begin
                                if (is_read) begin
                                    state <= ST_STOP;
                                end else begin
                                    phase <= PH_WDATA;
                                    shreg <= sh_wdata;
                                    state <= ST_TXBYTE;
                                end
                            end
                            PH_WDATA: state <= ST_STOP;
                            default:  state <= ST_RXBYTE;
                        endcase
                    end
                end
                ST_RXBYTE: if (phy_done) begin
                    shreg <= {shreg[6:0], phy_rx};
                    if (bitcnt == 3'd0) begin
                        rdata <= {shreg[6:0], phy_rx};
                        state <= ST_RXNACK;
                    end else begin
                        bitcnt <= bitcnt - 3'd1;
                    end
                end
                ST_RXNACK: if (phy_done) state <= ST_STOP;
                ST_STOP: if (phy_done) begin
                    // A read splits into an address frame and a data frame
                    if (is_read && phase == PH_SUB && !st_nack) begin
                        phase <= PH_IDR;
                        state <= ST_GAP;
                    end else begin
                        state   <= ST_IDLE;
                        st_done <= 1'b1;
                    end
                end
                ST_GAP: if (phy_done) state <= ST_START;
                default: state <= ST_IDLE;
            endcase
        end
    end

    sccb_phy #(
        .QTR_DIV (QTR_DIV)
    ) u_phy (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (phy_req),
        .op      (phy_op),
        .tx_bit  (phy_tx),
        .siod_in (siod_in),
        .done    (phy_done),
        .rx_bit  (phy_rx),
        .sioc    (sioc),
        .siod_oe (siod_oe)
    );

endmodule

`default_nettype wire

// File: tb/tb_sccb_ctrl.sv
// ============================================================================
// Module : tb_sccb_ctrl
// Brief  : Directed bench for sccb_ctrl with an SCCB camera slave model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sccb_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] sccb_MCmd = 3'd0;
    logic [7:0] sccb_MAddr = 8'h00;
    logic [7:0] sccb_MData = 8'h00;
    logic       sccb_SCmdAccept;
    logic [7:0] sccb_SData;
    logic [1:0] sccb_SResp;
    logic       sioc;
    logic       siod_oe;
    logic       siod_in;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic       acc;
    logic [1:0] rsp;
    logic [7:0] rd;

    // Slave model state
    logic       slave_drv = 1'b0;
    logic       nack_id = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic [7:0] rx_bytes[$];
    int         starts = 0, stops = 0, mnacks = 0;
    logic       p_sioc = 1'b1, p_siod = 1'b1;
    logic       in_frame = 1'b0, rd_mode = 1'b0, rd_next = 1'b0, mack_pend = 1'b0;
    int         bitn = 0, byte_idx = 0;
    logic [7:0] sr = 8'h00;
    logic       siod_line;

    assign siod_line = (siod_oe || slave_drv) ? 1'b0 : 1'b1;
    assign siod_in   = siod_line;

    always #5 clk = ~clk;

    sccb_ctrl #(.QTR_DIV(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sccb_MCmd       (sccb_MCmd),
        .sccb_MAddr      (sccb_MAddr),
        .sccb_MData      (sccb_MData),
        .sccb_SCmdAccept (sccb_SCmdAccept),
        .sccb_SData      (sccb_SData),
        .sccb_SResp      (sccb_SResp),
        .sioc            (sioc),
        .siod_oe         (siod_oe),
        .siod_in         (siod_in),
        .busy            (busy)
    );

    // Camera-side SCCB slave: decodes start/stop, acks bytes, serves read data
    always @(sioc or siod_line) begin
        if (siod_line !== p_siod && sioc === 1'b1 && p_sioc === 1'b1) begin
            if (siod_line === 1'b0) begin
                starts++;
                in_frame = 1'b1; bitn = 0; byte_idx = 0;
                rd_mode = 1'b0; rd_next = 1'b0; mack_pend = 1'b0;
            end else begin
                stops++;
                in_frame = 1'b0; slave_drv = 1'b0;
            end
        end
        if (sioc === 1'b1 && p_sioc === 1'b0 && in_frame) begin
            if (bitn < 8) sr = {sr[6:0], siod_line};
            else if (mack_pend) begin
                if (siod_line === 1'b1) mnacks++;
                mack_pend = 1'b0;
            end
            bitn++;
        end
        if (sioc === 1'b0 && p_sioc === 1'b1 && in_frame) begin
            if (bitn == 8) begin
                if (rd_mode) begin
                    slave_drv = 1'b0; rd_mode = 1'b0; mack_pend = 1'b1;
                end else begin
                    rx_bytes.push_back(sr);
                    if (byte_idx == 0 && sr[0]) rd_next = 1'b1;
                    slave_drv = !(nack_id && byte_idx == 0);
                end
            end else if (bitn == 9) begin
                bitn = 0; byte_idx++; slave_drv = 1'b0;
                if (rd_next) begin rd_mode = 1'b1; rd_next = 1'b0; end
            end
            if (rd_mode && bitn < 8) slave_drv = !tx_data[7 - bitn];
        end
        p_sioc = sioc;
        p_siod = siod_line;
    end

    task automatic ocp(input logic [2:0] cmd, input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        sccb_MCmd = cmd; sccb_MAddr = addr; sccb_MData = data;
        #1 acc = sccb_SCmdAccept;
        @(negedge clk);
        rsp = sccb_SResp; rd = sccb_SData;
        sccb_MCmd = 3'd0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL %s_timeout: busy=%b required 0", name, busy); end
    endtask

    task automatic check_bytes(input string name, input int base, input logic [7:0] exp[$]);
        checks++;
        if (rx_bytes.size() - base != exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes required %0d", name, rx_bytes.size() - base, exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (rx_bytes[base + i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s_byte%0d: got %h required %h", name, i, rx_bytes[base + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (sccb_SResp !== 2'd0) begin errors++; $display("FAIL reset_sresp: got %0d required 0", sccb_SResp); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (sccb_SCmdAccept !== 1'b0) begin errors++; $display("FAIL reset_accept: got %b required 0", sccb_SCmdAccept); end
        ocp(3'd2, 8'h02, 8'h00);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rd_dev_accept: got %b required 1", acc); end
        checks++; if (rsp !== 2'd1 || rd !== 8'h21) begin errors++; $display("FAIL rd_devaddr: got resp %0d data %h required 1 21", rsp, rd); end
    endtask

    task automatic test_write();
        int b0, s0, p0;
        b0 = rx_bytes.size(); s0 = starts; p0 = stops;
        ocp(3'd1, 8'h03, 8'h12);
        ocp(3'd1, 8'h04, 8'h80);
        ocp(3'd1, 8'h00, 8'h01);
        checks++; if (rsp !== 2'd1) begin errors++; $display("FAIL wr_start_resp: got %0d required 1", rsp); end
        ocp(3'd2, 8'h01, 8'h00);
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL wr_status_busy: got %h required 01", rd); end
        ocp(3'd1, 8'h00, 8'h01);
        checks++; if (rsp !== 2'd2) begin errors++; $display("FAIL start_while_busy: got %0d required 2", rsp); end
        wait_idle("write");
        ocp(3'd2, 8'h01, 8'h00);
        checks++; if (rd !== 8'h04) begin errors++; $display("FAIL wr_status_done: got %h required 04", rd); end
        check_bytes("wr", b0, '{8'h42, 8'h12, 8'h80});
        checks++; if (starts - s0 != 1 || stops - p0 != 1) begin errors++; $display("FAIL wr_framing: got starts %0d stops %0d required 1 1", starts - s0, stops - p0); end
        checks++; if (sioc !== 1'b1 || siod_oe !== 1'b0) begin errors++; $display("FAIL wr_bus_idle: got sioc %b oe %b required 1 0", sioc, siod_oe); end
    endtask

    task automatic test_read();
        int b0, s0, p0, n0;
        b0 = rx_bytes.size(); s0 = starts; p0 = stops; n0 = mnacks;
        tx_data = 8'h76;
        ocp(3'd1, 8'h03, 8'h0A);
        ocp(3'd1, 8'h00, 8'h02);
        ocp(3'd2, 8'h01, 8'h00);
        checks++; if (rd !== 8'h01) begin errors++; $display("FAIL rd_status_busy: got %h required 01", rd); end
        wait_idle("read");
        check_bytes("rd", b0, '{8'h42, 8'h0A, 8'h43});
        checks++; if (starts - s0 != 2 || stops - p0 != 2) begin errors++; $display("FAIL rd_framing: got starts %0d stops %0d required 2 2", starts - s0, stops - p0); end
        checks++; if (mnacks - n0 != 1) begin errors++; $display("FAIL rd_master_nack: got %0d required 1", mnacks - n0); end
        ocp(3'd2, 8'h05, 8'h00);
        checks++; if (rsp !== 2'd1 || rd !== 8'h76) begin errors++; $display("FAIL rd_rdata: got resp %0d data %h required 1 76", rsp, rd); end
        ocp(3'd2, 8'h01, 8'h00);
        checks++; if (rd !== 8'h04) begin errors++; $display("FAIL rd_status_done: got %h required 04", rd); end
    endtask

    task automatic test_nack();
        int b0, s0, p0;
        b0 = rx_bytes.size(); s0 = starts; p0 = stops;
        nack_id = 1'b1;
        tx_data = 8'hC3;
        ocp(3'd1, 8'h00, 8'h02);
        wait_idle("nack");
        nack_id = 1'b0;
        check_bytes("nack", b0, '{8'h42});
        checks++; if (starts - s0 != 1 || stops - p0 != 1) begin errors++; $display("FAIL nack_framing: got starts %0d stops %0d required 1 1", starts - s0, stops - p0); end
        ocp(3'd2, 8'h01, 8'h00);
        checks++; if (rd !== 8'h06) begin errors++; $display("FAIL nack_status: got %h required 06", rd); end
        checks++; if (sioc !== 1'b1 || siod_oe !== 1'b0) begin errors++; $display("FAIL nack_bus_idle: got sioc %b oe %b required 1 0", sioc, siod_oe); end
        ocp(3'd2, 8'h05, 8'h00);
        checks++; if (rd !== 8'h76) begin errors++; $display("FAIL nack_rdata_kept: got %h required 76", rd); end
    endtask

    task automatic test_errors();
        ocp(3'd2, 8'h07, 8'h00);
        checks++; if (rsp !== 2'd3 || rd !== 8'h00) begin errors++; $display("FAIL rd_unmapped: got resp %0d data %h required 3 00", rsp, rd); end
        ocp(3'd1, 8'h05, 8'h11);
        checks++; if (rsp !== 2'd3) begin errors++; $display("FAIL wr_rdata_ro: got %0d required 3", rsp); end
        ocp(3'd1, 8'h01, 8'h11);
        checks++; if (rsp !== 2'd3) begin errors++; $display("FAIL wr_status_ro: got %0d required 3", rsp); end
        ocp(3'd5, 8'h02, 8'h00);
        checks++; if (acc !== 1'b0 || rsp !== 2'd0) begin errors++; $display("FAIL mcmd5: got accept %b resp %0d required 0 0", acc, rsp); end
        ocp(3'd1, 8'h00, 8'hFC);
        checks++; if (rsp !== 2'd1 || busy !== 1'b0) begin errors++; $display("FAIL ctrl_nostart: got resp %0d busy %b required 1 0", rsp, busy); end
        ocp(3'd2, 8'h00, 8'h00);
        checks++; if (rsp !== 2'd1 || rd !== 8'h00) begin errors++; $display("FAIL rd_ctrl: got resp %0d data %h required 1 00", rsp, rd); end
        ocp(3'd1, 8'h02, 8'hFF);
        ocp(3'd2, 8'h02, 8'h00);
        checks++; if (rd !== 8'h7F) begin errors++; $display("FAIL devaddr_bit7: got %h required 7F", rd); end
        ocp(3'd1, 8'h02, 8'h21);
        ocp(3'd2, 8'h05, 8'h00);
        checks++; if (rd !== 8'h76) begin errors++; $display("FAIL rdata_no_side_effect: got %h required 76", rd); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sccb_MCmd = 3'd2; sccb_MAddr = 8'h02;
        @(negedge clk);
        checks++; if (sccb_SResp !== 2'd1 || sccb_SData !== 8'h21) begin errors++; $display("FAIL b2b_0: got resp %0d data %h required 1 21", sccb_SResp, sccb_SData); end
        sccb_MCmd = 3'd1; sccb_MAddr = 8'h04; sccb_MData = 8'h5A;
        @(negedge clk);
        checks++; if (sccb_SResp !== 2'd1 || sccb_SData !== 8'h00) begin errors++; $display("FAIL b2b_1: got resp %0d data %h required 1 00", sccb_SResp, sccb_SData); end
        sccb_MCmd = 3'd2; sccb_MAddr = 8'h04;
        @(negedge clk);
        checks++; if (sccb_SResp !== 2'd1 || sccb_SData !== 8'h5A) begin errors++; $display("FAIL b2b_2: got resp %0d data %h required 1 5A", sccb_SResp, sccb_SData); end
        sccb_MCmd = 3'd0;
        @(negedge clk);
        checks++; if (sccb_SResp !== 2'd0) begin errors++; $display("FAIL b2b_end: got resp %0d required 0", sccb_SResp); end
    endtask

    task automatic test_mid_reset();
        int b0;
        b0 = rx_bytes.size();
        ocp(3'd1, 8'h00, 8'h01);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rx_bytes.size() > b0) break;
        end
        checks++;
        if (rx_bytes.size() <= b0) begin errors++; $display("FAIL midrst_id_timeout: got %0d bytes required 1", rx_bytes.size() - b0); end
        repeat (40) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (sioc !== 1'b1 || siod_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_async: got sioc %b oe %b busy %b required 1 0 0", sioc, siod_oe, busy); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        b0 = rx_bytes.size();
        ocp(3'd1, 8'h03, 8'h33);
        ocp(3'd1, 8'h04, 8'h55);
        ocp(3'd1, 8'h00, 8'h01);
        wait_idle("midrst");
        check_bytes("midrst", b0, '{8'h42, 8'h33, 8'h55});
        ocp(3'd2, 8'h01, 8'h00);
        checks++; if (rd !== 8'h04) begin errors++; $display("FAIL midrst_status: got %h required 04", rd); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_errors();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
